// File: rtl/noc_pkg.sv
// Shared mesh constants, flit layout and helpers for the 3x3 NoC core interface.
// Flits are indexed [0:PL-1]; a packed flit_t maps its first field onto bit 0.
package noc_pkg;

  localparam int PL   = 32;
  localparam int X    = 3;
  localparam int Y    = 3;
  localparam int IDW  = $clog2(X * Y);
  localparam int PAYW = PL - 1 - 2 * IDW;

  typedef struct packed {
    logic            valid;
    logic [IDW-1:0]  dest;
    logic [IDW-1:0]  src;
    logic [PAYW-1:0] payload;
  } flit_t;

  localparam int VALID_IDX = 0;
  localparam int DEST_LO   = 1;
  localparam int DEST_HI   = IDW;
  localparam int SRC_LO    = IDW + 1;
  localparam int SRC_HI    = 2 * IDW;
  localparam int PAY_LO    = 2 * IDW + 1;

  function automatic int node_id(input int row, input int col);
    return row * X + col;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with extra-MSB pointers; head is read straight from storage.
// Push while full and pop while empty are ignored.
module flit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [0:WIDTH-1] din,
  output logic [0:WIDTH-1] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [0:WIDTH-1] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers hide stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/core_noc_iface.sv
// Network interface between a core and its local router port: TX FIFO with source
// stamping, RX FIFO with destination filtering, and saturating traffic counters.
module core_noc_iface #(
  parameter int PL       = 32,
  parameter int NODE_ID  = 0,
  parameter int X        = 3,
  parameter int Y        = 3,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:PL-1]    core_flit_i,
  output logic             core_stall_o,
  output logic [0:PL-1]    core_flit_o,
  input  logic             core_ack_i,
  output logic [0:PL-1]    noc_flit_o,
  input  logic             noc_ready_i,
  input  logic [0:PL-1]    noc_flit_i,
  output logic             noc_avail_o,
  output logic [CNT_W-1:0] tx_cnt_o,
  output logic [CNT_W-1:0] rx_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  import noc_pkg::*;

  localparam int              ID_W    = $clog2(X * Y);
  localparam int              STAMP_LO = DEST_LO + ID_W;
  localparam logic [ID_W-1:0] MY_ID   = ID_W'(NODE_ID);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:PL-1] tx_din;
  logic [0:PL-1] tx_dout;
  logic [0:PL-1] rx_dout;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic          rx_full, rx_empty, rx_push, rx_pop;
  logic          rx_valid, rx_for_me, rx_drop;

  always_comb begin
    tx_din = core_flit_i;
    tx_din[STAMP_LO +: ID_W] = MY_ID;
  end

  assign tx_push = core_flit_i[VALID_IDX] && !tx_full;
  assign tx_pop  = !tx_empty && noc_ready_i;

  flit_fifo #(.WIDTH(PL), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_din),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // A flit that is both misrouted and arriving while full is one drop, not two.
  assign rx_valid  = noc_flit_i[VALID_IDX];
  assign rx_for_me = (noc_flit_i[DEST_LO +: ID_W] == MY_ID);
  assign rx_push   = rx_valid && rx_for_me && !rx_full;
  assign rx_drop   = rx_valid && !rx_push;
  assign rx_pop    = core_ack_i && !rx_empty;

  flit_fifo #(.WIDTH(PL), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (noc_flit_i),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt_o   <= '0;
      rx_cnt_o   <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (tx_pop && (tx_cnt_o != CNT_MAX))     tx_cnt_o   <= tx_cnt_o + 1'b1;
      if (rx_push && (rx_cnt_o != CNT_MAX))    rx_cnt_o   <= rx_cnt_o + 1'b1;
      if (rx_drop && (drop_cnt_o != CNT_MAX))  drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  assign core_stall_o = tx_full;
  assign noc_avail_o  = !rx_full;
  assign noc_flit_o   = tx_empty ? '0 : tx_dout;
  assign core_flit_o  = rx_empty ? '0 : rx_dout;

endmodule

// File: tb/tb_core_noc_iface.sv
// Directed bench for core_noc_iface at NODE_ID=4 with 4-bit counters so saturation
// is reachable; every expected value is a hand-built flit or constant.
module tb_core_noc_iface;

  import noc_pkg::*;

  logic        clk;
  logic        rst;
  logic [0:31] core_flit_i;
  logic        core_stall_o;
  logic [0:31] core_flit_o;
  logic        core_ack_i;
  logic [0:31] noc_flit_o;
  logic        noc_ready_i;
  logic [0:31] noc_flit_i;
  logic        noc_avail_o;
  logic [3:0]  tx_cnt_o;
  logic [3:0]  rx_cnt_o;
  logic [3:0]  drop_cnt_o;

  int vectors;
  int miscompares;

  core_noc_iface #(
    .PL(32), .NODE_ID(4), .X(3), .Y(3), .TX_DEPTH(4), .RX_DEPTH(2), .CNT_W(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core_flit_i  (core_flit_i),
    .core_stall_o (core_stall_o),
    .core_flit_o  (core_flit_o),
    .core_ack_i   (core_ack_i),
    .noc_flit_o   (noc_flit_o),
    .noc_ready_i  (noc_ready_i),
    .noc_flit_i   (noc_flit_i),
    .noc_avail_o  (noc_avail_o),
    .tx_cnt_o     (tx_cnt_o),
    .rx_cnt_o     (rx_cnt_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:31] make_flit(input int dest, input int src, input int payload);
    flit_t f;
    f.valid   = 1'b1;
    f.dest    = IDW'(dest);
    f.src     = IDW'(src);
    f.payload = PAYW'(payload);
    return f;
  endfunction

  // Drive all inputs, then advance one rising edge and settle 1 time unit past it.
  task automatic applyStimulus(input logic [0:31] cf, input logic ack,
                               input logic [0:31] nf, input logic rdy);
    core_flit_i = cf;
    core_ack_i  = ack;
    noc_flit_i  = nf;
    noc_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [0:31] zf;
    logic [0:31] held;
    logic [0:31] exp_head;
    logic [0:31] rx_a, rx_b;
    vectors     = 0;
    miscompares = 0;
    zf          = '0;

    rst = 1'b1;
    applyStimulus(zf, 1'b0, zf, 1'b0);
    applyStimulus(zf, 1'b0, zf, 1'b0);
    rst = 1'b0;
    checkOutput("rst_noc_flit", noc_flit_o, 32'h0);
    checkOutput("rst_core_flit", core_flit_o, 32'h0);
    checkOutput("rst_stall", 32'(core_stall_o), 32'd0);
    checkOutput("rst_avail", 32'(noc_avail_o), 32'd1);
    checkOutput("rst_tx_cnt", 32'(tx_cnt_o), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);

    // Single TX flit: src garbage must be replaced by 4.
    applyStimulus(make_flit(7, 15, 'hAB), 1'b0, zf, 1'b1);
    core_flit_i = zf;
    checkOutput("t1_noc_flit", noc_flit_o, make_flit(7, 4, 'hAB));
    checkOutput("t1_tx_cnt_pre", 32'(tx_cnt_o), 32'd0);
    applyStimulus(zf, 1'b0, zf, 1'b1);
    checkOutput("t1_tx_cnt", 32'(tx_cnt_o), 32'd1);
    checkOutput("t1_noc_empty", noc_flit_o, 32'h0);

    // Fill TX under backpressure; fifth flit is held by the stall.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(make_flit(2, 9, 'h100 + i), 1'b0, zf, 1'b0);
      checkOutput($sformatf("t2_stall_%0d", i), 32'(core_stall_o), (i >= 4) ? 32'd1 : 32'd0);
    end
    checkOutput("t2_head_held", noc_flit_o, make_flit(2, 4, 'h101));
    held = make_flit(2, 9, 'h105);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus((k <= 2) ? held : zf, 1'b0, zf, 1'b1);
      exp_head = (k < 5) ? make_flit(2, 4, 'h101 + k) : zf;
      checkOutput($sformatf("t2_head_%0d", k), noc_flit_o, exp_head);
    end
    checkOutput("t2_stall_end", 32'(core_stall_o), 32'd0);
    checkOutput("t2_tx_cnt", 32'(tx_cnt_o), 32'd6);

    // RX fill to full, overflow drop, then full + ack + incoming.
    rx_a = make_flit(4, 1, 'h11);
    rx_b = make_flit(4, 2, 'h22);
    applyStimulus(zf, 1'b0, rx_a, 1'b0);
    checkOutput("t3_avail_1", 32'(noc_avail_o), 32'd1);
    applyStimulus(zf, 1'b0, rx_b, 1'b0);
    checkOutput("t3_avail_2", 32'(noc_avail_o), 32'd0);
    checkOutput("t3_rx_cnt_2", 32'(rx_cnt_o), 32'd2);
    checkOutput("t3_head_a", core_flit_o, rx_a);
    applyStimulus(zf, 1'b0, make_flit(4, 3, 'h33), 1'b0);
    checkOutput("t3_drop_cnt", 32'(drop_cnt_o), 32'd1);
    checkOutput("t3_rx_cnt", 32'(rx_cnt_o), 32'd2);
    applyStimulus(zf, 1'b1, make_flit(4, 5, 'h55), 1'b0);
    checkOutput("t5_head_b", core_flit_o, rx_b);
    checkOutput("t5_drop_cnt", 32'(drop_cnt_o), 32'd2);
    checkOutput("t5_rx_cnt", 32'(rx_cnt_o), 32'd2);
    checkOutput("t5_avail", 32'(noc_avail_o), 32'd1);
    applyStimulus(zf, 1'b1, zf, 1'b0);
    checkOutput("t3_rx_empty", core_flit_o, 32'h0);
    applyStimulus(zf, 1'b1, zf, 1'b0);
    checkOutput("t3_ack_empty", core_flit_o, 32'h0);

    // Misrouted flit to node 3.
    applyStimulus(zf, 1'b0, make_flit(3, 0, 'h77), 1'b0);
    checkOutput("t4_drop_cnt", 32'(drop_cnt_o), 32'd3);
    checkOutput("t4_core_flit", core_flit_o, 32'h0);
    checkOutput("t4_rx_cnt", 32'(rx_cnt_o), 32'd2);
    noc_flit_i = zf;

    // Reset with three flits queued in TX.
    for (int i = 1; i <= 3; i++) applyStimulus(make_flit(5, 0, 'h200 + i), 1'b0, zf, 1'b0);
    checkOutput("t6_pre_head", noc_flit_o, make_flit(5, 4, 'h201));
    rst = 1'b1;
    applyStimulus(zf, 1'b0, zf, 1'b0);
    rst = 1'b0;
    checkOutput("t6_noc_flit", noc_flit_o, 32'h0);
    checkOutput("t6_stall", 32'(core_stall_o), 32'd0);
    checkOutput("t6_avail", 32'(noc_avail_o), 32'd1);
    checkOutput("t6_tx_cnt", 32'(tx_cnt_o), 32'd0);
    checkOutput("t6_rx_cnt", 32'(rx_cnt_o), 32'd0);
    checkOutput("t6_drop_cnt", 32'(drop_cnt_o), 32'd0);

    // Saturation of all three 4-bit counters.
    for (int i = 0; i < 17; i++) applyStimulus(make_flit(1, 0, i), 1'b0, zf, 1'b1);
    applyStimulus(zf, 1'b0, zf, 1'b1);
    checkOutput("sat_tx_cnt", 32'(tx_cnt_o), 32'd15);
    checkOutput("sat_tx_drained", noc_flit_o, 32'h0);
    for (int i = 0; i < 15; i++) applyStimulus(zf, 1'b1, make_flit(4, 0, i), 1'b0);
    checkOutput("sat_rx_cnt_15", 32'(rx_cnt_o), 32'd15);
    for (int i = 0; i < 3; i++) applyStimulus(zf, 1'b1, make_flit(4, 0, i), 1'b0);
    checkOutput("sat_rx_cnt_hold", 32'(rx_cnt_o), 32'd15);
    for (int i = 0; i < 17; i++) applyStimulus(zf, 1'b1, make_flit(0, 0, i), 1'b0);
    checkOutput("sat_drop_cnt", 32'(drop_cnt_o), 32'd15);
    applyStimulus(zf, 1'b1, zf, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
